// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the pipeline hazard control slice.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } if_smash_state_t;

  localparam logic FALSE = 1'b0;
  localparam logic TRUE  = 1'b1;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for the multi-cycle unit: per-register pending bits,
// outstanding-op counter and the RAW/WAW/busy compares against DEC.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset_n,
  input  logic                      i_Enable,
  input  logic                      i_Issue,
  input  logic [REG_ADDR_WIDTH-1:0] i_Issue_Addr,
  input  logic                      i_Complete,
  input  logic [REG_ADDR_WIDTH-1:0] i_Complete_Addr,
  input  logic                      i_Uses_RS,
  input  logic                      i_Uses_RT,
  input  logic [REG_ADDR_WIDTH-1:0] i_RS_Addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_RT_Addr,
  input  logic                      i_Writes_Back,
  input  logic [REG_ADDR_WIDTH-1:0] i_Write_Addr,
  output logic                      o_RAW,
  output logic                      o_WAW,
  output logic                      o_Busy
);

  localparam int unsigned NUM_REGS  = 2 ** REG_ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0]  pending_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 do_set;
  logic                 do_clear;
  logic                 do_inc;

  // Issue wins over a same-register completion, and re-marking an already
  // pending register does not count twice, so bits and counter stay consistent.
  always_comb begin
    do_set   = i_Enable && i_Issue && (i_Issue_Addr != '0);
    do_clear = i_Enable && i_Complete && pending_q[i_Complete_Addr] &&
               !(do_set && (i_Issue_Addr == i_Complete_Addr));
    do_inc   = do_set && !pending_q[i_Issue_Addr];
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      if (do_clear) pending_q[i_Complete_Addr] <= FALSE;
      if (do_set)   pending_q[i_Issue_Addr]    <= TRUE;
      case ({do_inc, do_clear})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    o_RAW  = (i_Uses_RS && pending_q[i_RS_Addr]) ||
             (i_Uses_RT && pending_q[i_RT_Addr]);
    o_WAW  = i_Writes_Back && pending_q[i_Write_Addr];
    o_Busy = (count_q == CNT_MAX);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/smash generation, IF redirect, IF-smash tracking and stall statistics
// for the five-stage MIPS pipeline with a multi-cycle functional unit.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned LOAD_USE_STAGES = 1,
  parameter int unsigned STALL_CNT_WIDTH = 32
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset_n,
  input  logic                       i_FlashLoader_Done,
  input  logic                       i_Done,
  input  logic                       i_DEC_Uses_RS,
  input  logic                       i_DEC_Uses_RT,
  input  logic [REG_ADDR_WIDTH-1:0]  i_DEC_RS_Addr,
  input  logic [REG_ADDR_WIDTH-1:0]  i_DEC_RT_Addr,
  input  logic                       i_DEC_Writes_Back,
  input  logic [REG_ADDR_WIDTH-1:0]  i_DEC_Write_Addr,
  input  logic                       i_DEC_Long_Op,
  input  logic                       i_DEC_Branch_Instruction,
  input  logic                       i_DEC_Branch_Prediction,
  input  logic                       i_DEC_Jump_Instruction,
  input  logic [ADDRESS_WIDTH-1:0]   i_DEC_Branch_Target,
  input  logic                       i_IF_Done,
  input  logic                       i_EX_Writes_Back,
  input  logic                       i_EX_Uses_Mem,
  input  logic [REG_ADDR_WIDTH-1:0]  i_EX_Write_Addr,
  input  logic                       i_EX_Branch,
  input  logic [ADDRESS_WIDTH-1:0]   i_EX_Branch_Target,
  input  logic                       i_MEM_Writes_Back,
  input  logic                       i_MEM_Uses_Mem,
  input  logic                       i_MEM_Done,
  input  logic [REG_ADDR_WIDTH-1:0]  i_MEM_Write_Addr,
  input  logic                       i_LU_Complete,
  input  logic [REG_ADDR_WIDTH-1:0]  i_LU_Write_Addr,
  output logic                       o_IF_Branch,
  output logic [ADDRESS_WIDTH-1:0]   o_IF_Branch_Target,
  output logic                       o_IF_Stall,
  output logic                       o_IF_Smash,
  output logic                       o_DEC_Stall,
  output logic                       o_DEC_Smash,
  output logic                       o_EX_Stall,
  output logic                       o_EX_Smash,
  output logic                       o_MEM_Stall,
  output logic                       o_MEM_Smash,
  output logic                       o_WB_Stall,
  output logic                       o_WB_Smash,
  output logic                       o_LU_Busy,
  output logic [STALL_CNT_WIDTH-1:0] o_Stall_Cycles
);

  logic                       executing;
  logic                       sb_raw;
  logic                       sb_waw;
  logic                       sb_busy;
  logic                       load_use;
  logic                       dec_hazard;
  logic                       mem_stall;
  logic                       dec_stall;
  logic                       if_stall;
  logic                       dec_redirect;
  logic                       issue;
  logic                       redirect_valid_q;
  logic [ADDRESS_WIDTH-1:0]   redirect_target_q;
  if_smash_state_t            state_q;
  if_smash_state_t            state_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

  function automatic logic load_hit(input logic                      uses,
                                    input logic [REG_ADDR_WIDTH-1:0] src);
    logic ex_hit;
    logic mem_hit;
    ex_hit  = i_EX_Writes_Back && i_EX_Uses_Mem && (src == i_EX_Write_Addr);
    mem_hit = (LOAD_USE_STAGES >= 2) && i_MEM_Writes_Back && i_MEM_Uses_Mem &&
              (src == i_MEM_Write_Addr);
    return uses && (src != '0) && (ex_hit || mem_hit);
  endfunction

  hazard_scoreboard #(
    .REG_ADDR_WIDTH  (REG_ADDR_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .i_Clk           (i_Clk),
    .i_Reset_n       (i_Reset_n),
    .i_Enable        (executing),
    .i_Issue         (issue),
    .i_Issue_Addr    (i_DEC_Write_Addr),
    .i_Complete      (i_LU_Complete),
    .i_Complete_Addr (i_LU_Write_Addr),
    .i_Uses_RS       (i_DEC_Uses_RS),
    .i_Uses_RT       (i_DEC_Uses_RT),
    .i_RS_Addr       (i_DEC_RS_Addr),
    .i_RT_Addr       (i_DEC_RT_Addr),
    .i_Writes_Back   (i_DEC_Writes_Back),
    .i_Write_Addr    (i_DEC_Write_Addr),
    .o_RAW           (sb_raw),
    .o_WAW           (sb_waw),
    .o_Busy          (sb_busy)
  );

  always_comb begin
    executing  = i_FlashLoader_Done && !i_Done;
    load_use   = load_hit(i_DEC_Uses_RS, i_DEC_RS_Addr) ||
                 load_hit(i_DEC_Uses_RT, i_DEC_RT_Addr);
    dec_hazard = sb_raw || sb_waw || (i_DEC_Long_Op && sb_busy) || load_use ||
                 ((i_DEC_Branch_Instruction || i_DEC_Jump_Instruction) && !i_IF_Done);
    mem_stall  = !i_MEM_Done;
    dec_stall  = mem_stall || dec_hazard;
    if_stall   = dec_stall || !i_IF_Done;
    issue      = i_DEC_Long_Op && !dec_stall && executing;

    o_WB_Stall  = !executing;
    o_WB_Smash  = !executing;
    o_MEM_Stall = !executing || mem_stall;
    o_MEM_Smash = !executing || mem_stall;
    o_EX_Stall  = !executing || mem_stall;
    o_EX_Smash  = !executing;
    o_DEC_Stall = !executing || dec_stall;
    o_DEC_Smash = !executing || dec_hazard;
    o_IF_Stall  = !executing || if_stall;
    o_IF_Smash  = !executing || i_EX_Branch || !i_IF_Done ||
                  ((state_q == PEND) && i_IF_Done);
    o_LU_Busy   = sb_busy;
  end

  always_comb begin
    dec_redirect       = (i_DEC_Branch_Instruction && i_DEC_Branch_Prediction) ||
                         i_DEC_Jump_Instruction;
    o_IF_Branch        = FALSE;
    o_IF_Branch_Target = '0;
    if (executing) begin
      if (i_EX_Branch) begin
        o_IF_Branch        = TRUE;
        o_IF_Branch_Target = i_EX_Branch_Target;
      end else if (dec_redirect) begin
        o_IF_Branch        = TRUE;
        o_IF_Branch_Target = i_DEC_Branch_Target;
      end else if (redirect_valid_q) begin
        o_IF_Branch        = TRUE;
        o_IF_Branch_Target = redirect_target_q;
      end
    end
  end

  // A held DEC redirect never overwrites a latched EX one: the mispredict
  // means the instruction still sitting in DEC is on the wrong path.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      redirect_valid_q  <= FALSE;
      redirect_target_q <= '0;
    end else if (executing) begin
      if (if_stall) begin
        if (i_EX_Branch) begin
          redirect_valid_q  <= TRUE;
          redirect_target_q <= i_EX_Branch_Target;
        end else if (dec_redirect && !redirect_valid_q) begin
          redirect_valid_q  <= TRUE;
          redirect_target_q <= i_DEC_Branch_Target;
        end
      end else begin
        redirect_valid_q <= FALSE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_EX_Branch && !i_IF_Done) state_d = PEND;
      PEND:    if (i_IF_Done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
    end else if (executing) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      stall_cnt_q <= '0;
    end else if (executing && dec_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign o_Stall_Cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: default instance plus a two-stage
// load-use instance with a 4-bit stall counter, driven from the same inputs.
module tb_hazard_control_unit;

  logic        clk;
  logic        rst_n;
  logic        fl_done, done;
  logic        uses_rs, uses_rt, wb, long_op, br, pred, jmp;
  logic [4:0]  rs, rt, wr_addr;
  logic [31:0] dec_tgt;
  logic        if_done;
  logic        ex_wb, ex_mem, ex_br;
  logic [4:0]  ex_addr;
  logic [31:0] ex_tgt;
  logic        mem_wb, mem_mem, mem_done;
  logic [4:0]  mem_addr;
  logic        lu_cmp;
  logic [4:0]  lu_addr;

  logic        a_if_br, a_if_stall, a_if_smash, a_dec_stall, a_dec_smash;
  logic        a_ex_stall, a_ex_smash, a_mem_stall, a_mem_smash, a_wb_stall, a_wb_smash;
  logic        a_busy;
  logic [31:0] a_if_tgt, a_cnt;

  logic        b_if_br, b_if_stall, b_if_smash, b_dec_stall, b_dec_smash;
  logic        b_ex_stall, b_ex_smash, b_mem_stall, b_mem_smash, b_wb_stall, b_wb_smash;
  logic        b_busy;
  logic [31:0] b_if_tgt;
  logic [3:0]  b_cnt;

  int unsigned n_checks;
  int unsigned n_errors;

  hazard_control_unit dut_a (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_FlashLoader_Done(fl_done), .i_Done(done),
    .i_DEC_Uses_RS(uses_rs), .i_DEC_Uses_RT(uses_rt), .i_DEC_RS_Addr(rs), .i_DEC_RT_Addr(rt),
    .i_DEC_Writes_Back(wb), .i_DEC_Write_Addr(wr_addr), .i_DEC_Long_Op(long_op),
    .i_DEC_Branch_Instruction(br), .i_DEC_Branch_Prediction(pred),
    .i_DEC_Jump_Instruction(jmp), .i_DEC_Branch_Target(dec_tgt), .i_IF_Done(if_done),
    .i_EX_Writes_Back(ex_wb), .i_EX_Uses_Mem(ex_mem), .i_EX_Write_Addr(ex_addr),
    .i_EX_Branch(ex_br), .i_EX_Branch_Target(ex_tgt),
    .i_MEM_Writes_Back(mem_wb), .i_MEM_Uses_Mem(mem_mem), .i_MEM_Done(mem_done),
    .i_MEM_Write_Addr(mem_addr), .i_LU_Complete(lu_cmp), .i_LU_Write_Addr(lu_addr),
    .o_IF_Branch(a_if_br), .o_IF_Branch_Target(a_if_tgt),
    .o_IF_Stall(a_if_stall), .o_IF_Smash(a_if_smash),
    .o_DEC_Stall(a_dec_stall), .o_DEC_Smash(a_dec_smash),
    .o_EX_Stall(a_ex_stall), .o_EX_Smash(a_ex_smash),
    .o_MEM_Stall(a_mem_stall), .o_MEM_Smash(a_mem_smash),
    .o_WB_Stall(a_wb_stall), .o_WB_Smash(a_wb_smash),
    .o_LU_Busy(a_busy), .o_Stall_Cycles(a_cnt)
  );

  hazard_control_unit #(
    .LOAD_USE_STAGES (2),
    .STALL_CNT_WIDTH (4)
  ) dut_b (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_FlashLoader_Done(fl_done), .i_Done(done),
    .i_DEC_Uses_RS(uses_rs), .i_DEC_Uses_RT(uses_rt), .i_DEC_RS_Addr(rs), .i_DEC_RT_Addr(rt),
    .i_DEC_Writes_Back(wb), .i_DEC_Write_Addr(wr_addr), .i_DEC_Long_Op(long_op),
    .i_DEC_Branch_Instruction(br), .i_DEC_Branch_Prediction(pred),
    .i_DEC_Jump_Instruction(jmp), .i_DEC_Branch_Target(dec_tgt), .i_IF_Done(if_done),
    .i_EX_Writes_Back(ex_wb), .i_EX_Uses_Mem(ex_mem), .i_EX_Write_Addr(ex_addr),
    .i_EX_Branch(ex_br), .i_EX_Branch_Target(ex_tgt),
    .i_MEM_Writes_Back(mem_wb), .i_MEM_Uses_Mem(mem_mem), .i_MEM_Done(mem_done),
    .i_MEM_Write_Addr(mem_addr), .i_LU_Complete(lu_cmp), .i_LU_Write_Addr(lu_addr),
    .o_IF_Branch(b_if_br), .o_IF_Branch_Target(b_if_tgt),
    .o_IF_Stall(b_if_stall), .o_IF_Smash(b_if_smash),
    .o_DEC_Stall(b_dec_stall), .o_DEC_Smash(b_dec_smash),
    .o_EX_Stall(b_ex_stall), .o_EX_Smash(b_ex_smash),
    .o_MEM_Stall(b_mem_stall), .o_MEM_Smash(b_mem_smash),
    .o_WB_Stall(b_wb_stall), .o_WB_Smash(b_wb_smash),
    .o_LU_Busy(b_busy), .o_Stall_Cycles(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    uses_rs = 0; uses_rt = 0; rs = '0; rt = '0; wb = 0; wr_addr = '0; long_op = 0;
    br = 0; pred = 0; jmp = 0; dec_tgt = '0; if_done = 1;
    ex_wb = 0; ex_mem = 0; ex_addr = '0; ex_br = 0; ex_tgt = '0;
    mem_wb = 0; mem_mem = 0; mem_done = 1; mem_addr = '0;
    lu_cmp = 0; lu_addr = '0;
  endtask

  function automatic logic [9:0] ctrl_a();
    return {a_if_stall, a_if_smash, a_dec_stall, a_dec_smash, a_ex_stall,
            a_ex_smash, a_mem_stall, a_mem_smash, a_wb_stall, a_wb_smash};
  endfunction

  function automatic logic [9:0] ctrl_b();
    return {b_if_stall, b_if_smash, b_dec_stall, b_dec_smash, b_ex_stall,
            b_ex_smash, b_mem_stall, b_mem_smash, b_wb_stall, b_wb_smash};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 0; fl_done = 0; done = 0;
    clear_inputs();
    #3;
    check("rst_ctrl_a", ctrl_a(), 10'h3FF);
    check("rst_ctrl_b", ctrl_b(), 10'h3FF);
    check("rst_misc", {a_busy, a_if_br, b_busy, b_if_br}, 4'b0000);
    check("rst_tgt", a_if_tgt, 0);
    check("rst_cnt", {a_cnt, 28'd0, b_cnt}, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    fl_done = 1;
    #1;
    check("run_ctrl_a", ctrl_a(), 10'h000);
    check("run_ctrl_b", ctrl_b(), 10'h000);

    // Long op to r5, dependent RS=r5 held until the cycle after completion
    long_op = 1; wb = 1; wr_addr = 5;
    #1 check("t1_issue", a_dec_stall, 0);
    tick();
    clear_inputs(); uses_rs = 1; rs = 5;
    #1 check("t1_raw", {a_dec_stall, a_dec_smash, a_if_stall, b_dec_stall}, 4'b1111);
    tick(); tick();
    lu_cmp = 1; lu_addr = 5;
    #1 check("t1_no_bypass", a_dec_stall, 1);
    tick();
    lu_cmp = 0;
    #1 check("t1_release", a_dec_stall, 0);
    check("t1_cnt_a", a_cnt, 3);
    check("t1_cnt_b", b_cnt, 3);

    // Outstanding limit, same-cycle issue/complete, ignored completion
    clear_inputs(); long_op = 1; wb = 1; wr_addr = 3;
    #1 check("t2_issue3", a_dec_stall, 0);
    tick();
    wr_addr = 4;
    #1 check("t2_issue4", {a_dec_stall, a_busy}, 2'b00);
    tick();
    wr_addr = 6;
    #1 check("t2_busy", {a_busy, a_dec_stall, b_busy}, 3'b111);
    tick();
    lu_cmp = 1; lu_addr = 3;
    #1 check("t2_busy_hold", {a_busy, a_dec_stall}, 2'b11);
    tick();
    lu_cmp = 0;
    #1 check("t2_freed", {a_busy, a_dec_stall}, 2'b00);
    wb = 0; wr_addr = 4; lu_cmp = 1; lu_addr = 4;
    #1 check("t2_same_issue", a_dec_stall, 0);
    tick();
    clear_inputs(); uses_rs = 1; rs = 4;
    #1 check("t2_same_keep", a_dec_stall, 1);
    tick();
    clear_inputs(); long_op = 1; wb = 1; wr_addr = 9;
    #1 check("t2_issue9", {a_dec_stall, a_busy}, 2'b00);
    tick();
    clear_inputs();
    #1 check("t2_count_kept", a_busy, 1);
    lu_cmp = 1; lu_addr = 4; tick();
    lu_addr = 9; tick();
    lu_addr = 12; tick();
    lu_cmp = 0;
    #1 check("t2_drained", a_busy, 0);
    long_op = 1; wb = 1; wr_addr = 1; tick();
    wr_addr = 2; tick();
    clear_inputs();
    #1 check("t2_no_underflow", a_busy, 1);
    lu_cmp = 1; lu_addr = 1; tick();
    lu_addr = 2; tick();
    lu_cmp = 0;
    #1 check("t2_end_busy", a_busy, 0);
    check("t2_cnt_a", a_cnt, 6);
    check("t2_cnt_b", b_cnt, 6);

    // Load-use distance: A blocks on EX only, B on EX and MEM
    clear_inputs(); ex_wb = 1; ex_mem = 1; ex_addr = 7; uses_rt = 1; rt = 7;
    #1 check("t3_lu_ex", {a_dec_stall, a_dec_smash, b_dec_stall}, 3'b111);
    tick();
    ex_wb = 0; ex_mem = 0; mem_wb = 1; mem_mem = 1; mem_addr = 7;
    #1 check("t3_lu_mem", {a_dec_stall, b_dec_stall}, 2'b01);
    tick();
    mem_wb = 0; mem_mem = 0;
    #1 check("t3_clear", {a_dec_stall, b_dec_stall}, 2'b00);
    ex_wb = 1; ex_mem = 1; ex_addr = 0; rt = 0;
    #1 check("t3_r0", {a_dec_stall, b_dec_stall}, 2'b00);
    ex_addr = 7; rt = 7; uses_rt = 0;
    #1 check("t3_unused", {a_dec_stall, b_dec_stall}, 2'b00);
    ex_mem = 0; uses_rt = 1;
    #1 check("t3_alu_src", {a_dec_stall, b_dec_stall}, 2'b00);
    check("t3_cnt_a", a_cnt, 7);
    check("t3_cnt_b", b_cnt, 8);

    // Latched redirect: EX target overwrites an earlier DEC jump
    clear_inputs(); if_done = 0; jmp = 1; dec_tgt = 32'h400;
    #1 check("t4_dec_jump", {a_if_stall, a_dec_stall, a_if_br}, 3'b111);
    check("t4_dec_tgt", a_if_tgt, 32'h400);
    tick();
    jmp = 0; ex_br = 1; ex_tgt = 32'h800;
    #1 check("t4_ex_prio", a_if_tgt, 32'h800);
    tick();
    ex_br = 0; if_done = 1;
    #1 check("t4_release", {a_if_stall, a_if_br, a_if_smash}, 3'b011);
    check("t4_rel_tgt", a_if_tgt, 32'h800);
    tick();
    #1 check("t4_applied", {a_if_br, a_if_smash}, 2'b00);
    check("t4_applied_tgt", a_if_tgt, 0);
    br = 1; pred = 0; dec_tgt = 32'h200;
    #1 check("t4_nopred", a_if_br, 0);
    pred = 1;
    #1 check("t4_pred", {a_if_br, a_if_stall}, 2'b10);
    check("t4_pred_tgt", a_if_tgt, 32'h200);
    ex_br = 1; ex_tgt = 32'h900;
    #1 check("t4_ex_over_dec", a_if_tgt, 32'h900);
    check("t4_ex_smash", a_if_smash, 1);

    // IF-smash FSM across a three-cycle IMEM wait
    clear_inputs(); ex_br = 1; ex_tgt = 32'h123; if_done = 0;
    #1 check("t5_smash0", a_if_smash, 1);
    tick();
    ex_br = 0;
    #1 check("t5_smash1", {a_if_smash, a_if_br}, 2'b11);
    tick();
    #1 check("t5_smash2", a_if_smash, 1);
    tick();
    if_done = 1;
    #1 check("t5_smash_rise", a_if_smash, 1);
    check("t5_redirect", a_if_tgt, 32'h123);
    tick();
    #1 check("t5_idle", {a_if_smash, a_if_br}, 2'b00);
    check("t5_cnt_a", a_cnt, 8);

    // Halted core holds state; MEM wait chain; counter saturation on B
    clear_inputs(); mem_done = 0; done = 1; long_op = 1; wb = 1; wr_addr = 10;
    #1 check("t6_halt_ctrl", ctrl_a(), 10'h3FF);
    tick(); tick();
    check("t6_halt_cnt_a", a_cnt, 8);
    check("t6_halt_cnt_b", b_cnt, 9);
    done = 0; clear_inputs(); uses_rs = 1; rs = 10;
    #1 check("t6_no_issue", a_dec_stall, 0);
    clear_inputs(); mem_done = 0;
    #1 check("t6_mem_chain", ctrl_a(), 10'b1010101100);
    repeat (8) tick();
    check("t6_cnt_a", a_cnt, 16);
    check("t6_sat_b", b_cnt, 4'hF);
    tick();
    check("t6_sat_hold_b", b_cnt, 4'hF);
    check("t6_cnt_a2", a_cnt, 17);

    // Asynchronous reset in the middle of a stall
    clear_inputs(); long_op = 1; wb = 1; wr_addr = 5;
    tick();
    clear_inputs(); ex_br = 1; ex_tgt = 32'h55; if_done = 0; uses_rs = 1; rs = 5;
    #1 check("t7_pre", a_dec_stall, 1);
    tick();
    #2 rst_n = 0;
    ex_br = 0; if_done = 1;
    #1 check("t7_rst_ctrl", {a_dec_stall, a_if_smash, a_if_br, a_busy}, 4'b0000);
    check("t7_rst_tgt", a_if_tgt, 0);
    check("t7_rst_cnt", {a_cnt, 28'd0, b_cnt}, 0);
    rst_n = 1;
    tick();
    #1 check("t7_after", {a_dec_stall, a_if_smash}, 2'b00);
    check("t7_after_cnt", a_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
